// File: rtl/mot_shot_capture_if.sv
// Host read port of the MOT shot capture RAM: addressed strobe in, word and valid out.
interface mot_shot_capture_if #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DW     = 16
) ();
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DW-1:0]     rd_data;
  logic              rd_valid;

  modport master (output rd_en, output rd_addr, input rd_data, input rd_valid);
  modport slave  (input rd_en, input rd_addr, output rd_data, output rd_valid);
endinterface

// File: rtl/mot_shot_capture.sv
// Records one decimated shot of a signed signal into RAM on the sequencer memtrig edge,
// with per-shot sample count, missed-trigger count and running min/max.
module mot_shot_capture #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DW     = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_arm,
  input  logic                     i_memtrig,
  input  logic signed [DW-1:0]     i_s_in,
  input  logic [15:0]              i_dec,
  input  logic [ADDR_W:0]          i_n_samp,
  mot_shot_capture_if.slave        rd_if,
  output logic                     o_busy,
  output logic                     o_done,
  output logic [ADDR_W:0]          o_wr_count,
  output logic [7:0]               o_missed,
  output logic signed [DW-1:0]     o_s_min,
  output logic signed [DW-1:0]     o_s_max
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned CW    = ADDR_W + 1;
  localparam int unsigned DECW  = 16;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ARMED   = 2'd1;
  localparam logic [1:0] S_CAPTURE = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  localparam logic signed [DW-1:0] MIN_INIT = {1'b0, {(DW-1){1'b1}}};
  localparam logic signed [DW-1:0] MAX_INIT = {1'b1, {(DW-1){1'b0}}};
  localparam logic [CW-1:0]        N_MAX    = CW'(DEPTH);

  logic [1:0]              r_state, w_state_nxt;
  logic                    r_trig_d;
  logic [DECW-1:0]         r_dec_sh, w_dec_sh_nxt;
  logic [CW-1:0]           r_n_sh, w_n_sh_nxt;
  logic [DECW-1:0]         r_dcnt, w_dcnt_nxt;
  logic [CW-1:0]           r_wr_count, w_wr_count_nxt;
  logic [7:0]              r_missed, w_missed_nxt;
  logic signed [DW-1:0]    r_s_min, w_s_min_nxt;
  logic signed [DW-1:0]    r_s_max, w_s_max_nxt;
  logic                    r_busy, r_done;
  logic                    w_trig_edge, w_store, w_we;
  logic [DECW-1:0]         w_reload;
  logic [CW-1:0]           w_n_clamp, w_wr_inc;
  logic [7:0]              w_missed_inc;

  logic [DW-1:0]           r_mem [DEPTH];
  logic [DW-1:0]           r_rd_data;
  logic                    r_rd_valid;

  assign w_trig_edge  = i_memtrig & ~r_trig_d;
  assign w_reload     = (r_dec_sh == '0) ? '0 : r_dec_sh - DECW'(1);
  assign w_n_clamp    = (i_n_samp == '0) ? CW'(1) :
                        (i_n_samp > N_MAX) ? N_MAX : i_n_samp;
  assign w_wr_inc     = r_wr_count + CW'(1);
  assign w_missed_inc = (r_missed == 8'hFF) ? r_missed : r_missed + 8'd1;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state and datapath updates; the trigger cycle itself stores address 0
  always_comb begin
    w_state_nxt    = r_state;
    w_dec_sh_nxt   = r_dec_sh;
    w_n_sh_nxt     = r_n_sh;
    w_dcnt_nxt     = r_dcnt;
    w_wr_count_nxt = r_wr_count;
    w_missed_nxt   = r_missed;
    w_s_min_nxt    = r_s_min;
    w_s_max_nxt    = r_s_max;
    w_store        = 1'b0;
    w_we           = 1'b0;

    case (r_state)
      S_IDLE, S_DONE: begin
        if (w_trig_edge) w_missed_nxt = w_missed_inc;
        if (i_arm) begin
          w_state_nxt    = S_ARMED;
          w_wr_count_nxt = '0;
          w_s_min_nxt    = MIN_INIT;
          w_s_max_nxt    = MAX_INIT;
          w_dec_sh_nxt   = i_dec;
          w_n_sh_nxt     = w_n_clamp;
        end
      end
      S_ARMED: begin
        if (w_trig_edge) w_store = 1'b1;
      end
      S_CAPTURE: begin
        if (w_trig_edge) w_missed_nxt = w_missed_inc;
        if (r_dcnt == '0) w_store = 1'b1;
        else              w_dcnt_nxt = r_dcnt - DECW'(1);
      end
      default: w_state_nxt = S_IDLE;
    endcase

    if (w_store) begin
      w_we           = 1'b1;
      w_wr_count_nxt = w_wr_inc;
      w_dcnt_nxt     = w_reload;
      if (i_s_in < r_s_min) w_s_min_nxt = i_s_in;
      if (i_s_in > r_s_max) w_s_max_nxt = i_s_in;
      w_state_nxt    = (w_wr_inc >= r_n_sh) ? S_DONE : S_CAPTURE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_trig_d   <= 1'b0;
      r_dec_sh   <= '0;
      r_n_sh     <= CW'(1);
      r_dcnt     <= '0;
      r_wr_count <= '0;
      r_missed   <= '0;
      r_s_min    <= MIN_INIT;
      r_s_max    <= MAX_INIT;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_trig_d   <= i_memtrig;
      r_dec_sh   <= w_dec_sh_nxt;
      r_n_sh     <= w_n_sh_nxt;
      r_dcnt     <= w_dcnt_nxt;
      r_wr_count <= w_wr_count_nxt;
      r_missed   <= w_missed_nxt;
      r_s_min    <= w_s_min_nxt;
      r_s_max    <= w_s_max_nxt;
      r_busy     <= (w_state_nxt == S_ARMED) || (w_state_nxt == S_CAPTURE);
      r_done     <= (w_state_nxt == S_DONE);
    end
  end

  // Sample RAM write port
  always_ff @(posedge clk) begin
    if (w_we) r_mem[r_wr_count[ADDR_W-1:0]] <= i_s_in;
  end

  // Read port is read-first against a same-cycle write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= rd_if.rd_en;
      if (rd_if.rd_en) r_rd_data <= r_mem[rd_if.rd_addr];
    end
  end

  assign rd_if.rd_data  = r_rd_data;
  assign rd_if.rd_valid = r_rd_valid;
  assign o_busy         = r_busy;
  assign o_done         = r_done;
  assign o_wr_count     = r_wr_count;
  assign o_missed       = r_missed;
  assign o_s_min        = r_s_min;
  assign o_s_max        = r_s_max;

endmodule

// File: tb/tb_mot_shot_capture.sv
// Directed bench for mot_shot_capture: shot capture, decimation, trigger accounting, readback, bounds.
module tb_mot_shot_capture;

  logic               clk;
  logic               rst_n;
  logic               arm;
  logic               memtrig;
  logic signed [15:0] s_in;
  logic [15:0]        dec;
  logic [12:0]        n_samp;
  logic               busy;
  logic               done;
  logic [12:0]        wr_count;
  logic [7:0]         missed;
  logic signed [15:0] s_min;
  logic signed [15:0] s_max;

  int checks;
  int failures;

  mot_shot_capture_if #(.ADDR_W(12), .DW(16)) rd_if ();

  mot_shot_capture #(.ADDR_W(12), .DW(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_arm      (arm),
    .i_memtrig  (memtrig),
    .i_s_in     (s_in),
    .i_dec      (dec),
    .i_n_samp   (n_samp),
    .rd_if      (rd_if.slave),
    .o_busy     (busy),
    .o_done     (done),
    .o_wr_count (wr_count),
    .o_missed   (missed),
    .o_s_min    (s_min),
    .o_s_max    (s_max)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_arm(input logic [15:0] d, input logic [12:0] n);
    dec    = d;
    n_samp = n;
    arm    = 1'b1;
    tick();
    arm    = 1'b0;
  endtask

  task automatic read_word(input logic [11:0] a, output logic [15:0] d,
                           output logic v1, output logic v2);
    rd_if.rd_en   = 1'b1;
    rd_if.rd_addr = a;
    tick();
    rd_if.rd_en   = 1'b0;
    d  = rd_if.rd_data;
    v1 = rd_if.rd_valid;
    tick();
    v2 = rd_if.rd_valid;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (wr_count !== 13'd0) begin failures++; $display("FAIL reset_wr_count got=%0d exp=0", wr_count); end
    checks++; if (missed !== 8'd0) begin failures++; $display("FAIL reset_missed got=%0d exp=0", missed); end
    checks++; if (s_min !== 16'sh7FFF || s_max !== 16'sh8000) begin
      failures++; $display("FAIL reset_minmax got=%0d/%0d exp=32767/-32768", s_min, s_max); end
    checks++; if (rd_if.rd_valid !== 1'b0 || rd_if.rd_data !== 16'd0) begin
      failures++; $display("FAIL reset_rd got=%h/%b exp=0000/0", rd_if.rd_data, rd_if.rd_valid); end
  endtask

  task automatic test_basic_shot();
    do_arm(16'd1, 13'd8);
    checks++; if (busy !== 1'b1 || done !== 1'b0) begin
      failures++; $display("FAIL basic_armed busy=%b done=%b exp 1/0", busy, done); end
    for (int k = 0; k < 15; k++) begin
      s_in    = 16'(100 + k);
      memtrig = (100 + k >= 105);
      tick();
      if (k == 11) begin
        checks++; if (done !== 1'b0 || wr_count !== 13'd7) begin
          failures++; $display("FAIL basic_before_last done=%b wr=%0d exp 0/7", done, wr_count); end
      end
      if (k == 12) begin
        checks++; if (done !== 1'b1 || wr_count !== 13'd8) begin
          failures++; $display("FAIL basic_after_last done=%b wr=%0d exp 1/8", done, wr_count); end
      end
    end
    memtrig = 1'b0;
    tick();
    checks++; if (s_min !== 16'sd105 || s_max !== 16'sd112) begin
      failures++; $display("FAIL basic_minmax got=%0d/%0d exp=105/112", s_min, s_max); end
    checks++; if (busy !== 1'b0 || wr_count !== 13'd8) begin
      failures++; $display("FAIL basic_hold busy=%b wr=%0d exp 0/8", busy, wr_count); end
  endtask

  task automatic test_back_to_back_read();
    int bad;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      rd_if.rd_en   = 1'b1;
      rd_if.rd_addr = 12'(i);
      tick();
      if (rd_if.rd_valid !== 1'b1 || rd_if.rd_data !== 16'(105 + i)) begin
        bad++; $display("FAIL b2b_read addr=%0d got=%0d/%b exp=%0d/1", i, rd_if.rd_data, rd_if.rd_valid, 105 + i);
      end
    end
    rd_if.rd_en = 1'b0;
    tick();
    checks++; if (bad != 0) failures++;
    checks++; if (rd_if.rd_valid !== 1'b0) begin failures++; $display("FAIL b2b_valid_drop got=%b exp=0", rd_if.rd_valid); end
  endtask

  task automatic test_read_latency();
    logic [15:0] d;
    logic        v1, v2;
    read_word(12'd2, d, v1, v2);
    checks++; if (d !== 16'd107 || v1 !== 1'b1) begin
      failures++; $display("FAIL rd_latency got=%0d/%b exp=107/1", d, v1); end
    checks++; if (v2 !== 1'b0) begin failures++; $display("FAIL rd_valid_pulse got=%b exp=0", v2); end
  endtask

  task automatic test_decimation();
    logic [15:0] d;
    logic        v1, v2;
    logic [15:0] exp4 [3];
    exp4 = '{16'd10, 16'd14, 16'd18};
    do_arm(16'd4, 13'd3);
    for (int c = 0; c < 26; c++) begin
      s_in    = 16'(c);
      memtrig = (c >= 10);
      tick();
      if (c == 17) begin
        checks++; if (wr_count !== 13'd2 || done !== 1'b0) begin
          failures++; $display("FAIL dec4_mid wr=%0d done=%b exp 2/0", wr_count, done); end
      end
    end
    memtrig = 1'b0;
    tick();
    checks++; if (done !== 1'b1 || wr_count !== 13'd3) begin
      failures++; $display("FAIL dec4_done done=%b wr=%0d exp 1/3", done, wr_count); end
    for (int i = 0; i < 3; i++) begin
      read_word(12'(i), d, v1, v2);
      checks++; if (d !== exp4[i]) begin failures++; $display("FAIL dec4_ram addr=%0d got=%0d exp=%0d", i, d, exp4[i]); end
    end
    do_arm(16'd0, 13'd4);
    for (int c = 0; c < 12; c++) begin
      s_in    = 16'(c);
      memtrig = (c >= 3);
      tick();
    end
    memtrig = 1'b0;
    tick();
    checks++; if (wr_count !== 13'd4 || done !== 1'b1) begin
      failures++; $display("FAIL dec0_done wr=%0d done=%b exp 4/1", wr_count, done); end
    for (int i = 0; i < 4; i++) begin
      read_word(12'(i), d, v1, v2);
      checks++; if (d !== 16'(3 + i)) begin failures++; $display("FAIL dec0_ram addr=%0d got=%0d exp=%0d", i, d, 3 + i); end
    end
  endtask

  task automatic test_missed();
    logic [15:0] d;
    logic        v1, v2;
    logic        pat [6];
    pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    apply_reset();
    dec = 16'd1; n_samp = 13'd4;
    repeat (3) begin
      memtrig = 1'b1; tick();
      memtrig = 1'b0; tick();
    end
    checks++; if (missed !== 8'd3) begin failures++; $display("FAIL missed_idle got=%0d exp=3", missed); end
    arm = 1'b1; memtrig = 1'b1;
    tick();
    arm = 1'b0;
    checks++; if (busy !== 1'b1 || wr_count !== 13'd0 || missed !== 8'd4) begin
      failures++; $display("FAIL missed_simul busy=%b wr=%0d missed=%0d exp 1/0/4", busy, wr_count, missed); end
    memtrig = 1'b0;
    tick();
    checks++; if (wr_count !== 13'd0 || busy !== 1'b1) begin
      failures++; $display("FAIL missed_no_start wr=%0d busy=%b exp 0/1", wr_count, busy); end
    for (int k = 0; k < 6; k++) begin
      s_in    = 16'(200 + k);
      memtrig = pat[k];
      tick();
    end
    memtrig = 1'b0;
    tick();
    checks++; if (missed !== 8'd5 || wr_count !== 13'd4 || done !== 1'b1) begin
      failures++; $display("FAIL missed_capture missed=%0d wr=%0d done=%b exp 5/4/1", missed, wr_count, done); end
    read_word(12'd3, d, v1, v2);
    checks++; if (d !== 16'd203) begin failures++; $display("FAIL missed_capture_ram got=%0d exp=203", d); end
  endtask

  task automatic test_saturate();
    repeat (300) begin
      memtrig = 1'b1; tick();
      memtrig = 1'b0; tick();
    end
    checks++; if (missed !== 8'd255) begin failures++; $display("FAIL missed_sat got=%0d exp=255", missed); end
  endtask

  task automatic test_negative();
    logic signed [15:0] vals [4];
    vals = '{16'sd5, -16'sd32768, 16'sd32767, -16'sd1};
    do_arm(16'd1, 13'd4);
    checks++; if (s_min !== 16'sh7FFF || s_max !== 16'sh8000 || wr_count !== 13'd0 || done !== 1'b0) begin
      failures++; $display("FAIL rearm_clear min=%0d max=%0d wr=%0d done=%b", s_min, s_max, wr_count, done); end
    for (int k = 0; k < 4; k++) begin
      s_in    = vals[k];
      memtrig = 1'b1;
      tick();
    end
    memtrig = 1'b0;
    tick();
    checks++; if (s_min !== -16'sd32768 || s_max !== 16'sd32767) begin
      failures++; $display("FAIL neg_minmax got=%0d/%0d exp=-32768/32767", s_min, s_max); end
  endtask

  task automatic test_n_zero();
    logic [15:0] d;
    logic        v1, v2;
    do_arm(16'd1, 13'd0);
    s_in = 16'sd77; memtrig = 1'b1;
    tick();
    checks++; if (wr_count !== 13'd1 || done !== 1'b1) begin
      failures++; $display("FAIL nzero_done wr=%0d done=%b exp 1/1", wr_count, done); end
    s_in = 16'sd78;
    tick();
    memtrig = 1'b0;
    tick();
    checks++; if (wr_count !== 13'd1) begin failures++; $display("FAIL nzero_hold wr=%0d exp=1", wr_count); end
    read_word(12'd0, d, v1, v2);
    checks++; if (d !== 16'd77) begin failures++; $display("FAIL nzero_ram got=%0d exp=77", d); end
  endtask

  task automatic test_clamp();
    logic [15:0] d;
    logic        v1, v2;
    do_arm(16'd1, 13'd4101);
    memtrig = 1'b1;
    for (int k = 0; k < 4200; k++) begin
      s_in = 16'(k);
      tick();
      if (done) break;
    end
    checks++; if (done !== 1'b1 || wr_count !== 13'd4096) begin
      failures++; $display("FAIL clamp_done done=%b wr=%0d exp 1/4096", done, wr_count); end
    repeat (5) tick();
    memtrig = 1'b0;
    checks++; if (wr_count !== 13'd4096) begin failures++; $display("FAIL clamp_hold wr=%0d exp=4096", wr_count); end
    read_word(12'd4095, d, v1, v2);
    checks++; if (d !== 16'd4095) begin failures++; $display("FAIL clamp_last got=%0d exp=4095", d); end
    read_word(12'd0, d, v1, v2);
    checks++; if (d !== 16'd0) begin failures++; $display("FAIL clamp_nowrap got=%0d exp=0", d); end
  endtask

  task automatic test_reset_mid_capture();
    logic [15:0] d;
    logic        v1, v2;
    do_arm(16'd1, 13'd8);
    memtrig = 1'b1;
    for (int k = 0; k < 5; k++) begin
      s_in = 16'(300 + k);
      tick();
    end
    checks++; if (wr_count !== 13'd5 || busy !== 1'b1) begin
      failures++; $display("FAIL mid_pre wr=%0d busy=%b exp 5/1", wr_count, busy); end
    rst_n = 1'b0;
    memtrig = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || wr_count !== 13'd0 || done !== 1'b0 || missed !== 8'd0) begin
      failures++; $display("FAIL mid_reset busy=%b wr=%0d done=%b missed=%0d exp 0/0/0/0", busy, wr_count, done, missed); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    do_arm(16'd1, 13'd3);
    memtrig = 1'b1;
    for (int k = 0; k < 3; k++) begin
      s_in = 16'(50 + k);
      tick();
    end
    memtrig = 1'b0;
    checks++; if (wr_count !== 13'd3 || done !== 1'b1) begin
      failures++; $display("FAIL mid_reshot wr=%0d done=%b exp 3/1", wr_count, done); end
    for (int i = 0; i < 3; i++) begin
      read_word(12'(i), d, v1, v2);
      checks++; if (d !== 16'(50 + i)) begin failures++; $display("FAIL mid_reshot_ram addr=%0d got=%0d exp=%0d", i, d, 50 + i); end
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b0; arm = 1'b0; memtrig = 1'b0; s_in = '0; dec = 16'd1; n_samp = 13'd1;
    rd_if.rd_en = 1'b0; rd_if.rd_addr = '0;
    test_reset();
    test_basic_shot();
    test_back_to_back_read();
    test_read_latency();
    test_decimation();
    test_missed();
    test_saturate();
    test_negative();
    test_n_zero();
    test_clamp();
    test_reset_mid_capture();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mot_shot_capture.md
Name: mot_shot_capture

Overview:
- Downstream of the MOT FM/intensity sequencer. Records one shot of a 16-bit signed signal, such as the photodetector input or the sequencer's IntDiffOut, into on-chip RAM.
- Capture starts at the rising edge of the sequencer's memtrig. The signal is decimated by a programmable factor.
- The host reads the shot back over a simple addressed read port. Per-shot status is also provided: sample count, missed triggers, and running min/max.

Parameters:
ADDR_W, 12, RAM address width; depth = 2**ADDR_W samples
DW, 16, sample width (signed)

Ports:
clk  in  1  system clock (100 MHz)
rst_n  in  1  asynchronous active-low reset
arm  in  1  single-cycle pulse; arms capture for the next trigger
memtrig  in  1  level from sequencer; rising edge = trigger
s_in  in  DW  signed sample to record
dec  in  16  decimation; one sample stored every max(dec,1) clocks
n_samp  in  ADDR_W+1  samples per shot; 0 treated as 1, values > 2**ADDR_W clamped to 2**ADDR_W
rd_en  in  1  read strobe
rd_addr  in  ADDR_W  read address
rd_data  out  DW  RAM word at rd_addr
rd_valid  out  1  rd_data valid
busy  out  1  high in ARMED or CAPTURE
done  out  1  high in DONE
wr_count  out  ADDR_W+1  samples written this shot
missed  out  8  triggers seen while not ARMED (saturating)
s_min  out  DW  minimum stored sample this shot
s_max  out  DW  maximum stored sample this shot

Behaviour:
- Reset (async assert, sync deassert by rst_n release at clk edge):
  - State = IDLE; rd_data = 0, rd_valid = 0, busy = 0, done = 0, wr_count = 0, missed = 0.
  - s_min = +32767, s_max = -32768. RAM contents are undefined.
- Trigger edge detect: memtrig is registered once into trig_d; trig_edge = memtrig & ~trig_d.
- dec and n_samp are latched into shadow registers on arm. Changes while busy have no effect.
- States and transitions:
  - IDLE: arm -> ARMED. Arming clears wr_count, resets s_min/s_max to their reset values, and clears done. trig_edge -> missed++.
  - ARMED: trig_edge -> CAPTURE. The decimation counter is loaded to 0, so the sample on the trigger edge cycle is stored at address 0. arm is ignored.
  - CAPTURE:
    - When the decimation counter is 0: write s_in at address wr_count, wr_count++, update s_min/s_max (signed compare), reload the counter with max(dec,1)-1. Otherwise the counter decrements.
    - When wr_count reaches the latched n_samp -> DONE, on the cycle after the last write.
    - trig_edge in CAPTURE -> missed++; capture is not restarted.
  - DONE: holds results. arm -> ARMED (re-arm, same clear as from IDLE). trig_edge -> missed++.
- Simultaneous arm and trig_edge in IDLE or DONE: go to ARMED only. That trigger counts as missed and does not start capture.
- missed saturates at 255 and is cleared only by reset.
- Read port:
  - Synchronous RAM with 1-clock latency: rd_en at cycle t gives rd_data and rd_valid at t+1. rd_valid is a 1-cycle pulse per rd_en.
  - Reads are permitted in any state. A read during CAPTURE of an address being written the same cycle returns the old data (read-first).
- Addressing never wraps: a shot writes at most 2**ADDR_W samples.
- Reset mid-capture aborts to IDLE. The partial shot is lost and wr_count = 0.

Test Plan:
- Basic shot: reset, dec=1, n_samp=8, arm; s_in ramps 100,101,... each clock; memtrig rises when s_in=105 -> RAM[0..7]=105..112, wr_count=8, done=1 one cycle after the 8th write, s_min=105, s_max=112.
- Decimation: dec=4, n_samp=3, s_in = clock counter value c, trigger at c=10 -> RAM = 10,14,18. dec=0 behaves as dec=1.
- Missed/simultaneous triggers:
  - 3 memtrig edges in IDLE -> missed=3.
  - arm and trigger in the same cycle -> ARMED, missed=4.
  - A second edge during CAPTURE -> missed=5 and capture is unaffected.
  - 300 idle edges -> missed=255.
- Readback latency: rd_en at cycle t with rd_addr=2 -> rd_data=RAM[2], rd_valid=1 at t+1 only. A back-to-back rd_en stream yields one word per clock.
- Boundary:
  - n_samp=2**ADDR_W+5 -> clamps to 4096 samples and wr_count=4096.
  - n_samp=0 -> one sample stored.
  - Negative samples -32768/+32767 give the correct s_min/s_max.
- Reset mid-capture: assert rst_n=0 after 5 samples -> immediately busy=0, wr_count=0, state IDLE. Re-arm and trigger -> a clean new shot starting at address 0.
